// File: rtl/du_proto_pkg.sv
// Shared protocol definitions for the debug-unit host link: op codes,
// the acknowledge byte, the controller state encoding and length helpers.
package du_proto_pkg;

    localparam logic [2:0] OP_LOAD_INST  = 3'd1;
    localparam logic [2:0] OP_RUN        = 3'd2;
    localparam logic [2:0] OP_STEP       = 3'd3;
    localparam logic [2:0] OP_READ_REG   = 3'd4;
    localparam logic [2:0] OP_READ_MEM   = 3'd5;
    localparam logic [2:0] OP_READ_LATCH = 3'd6;

    localparam logic [7:0] ACK_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_OP  = 3'd1,
        ST_SEND_ARG = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_RECV     = 3'd4,
        ST_DELIVER  = 3'd5,
        ST_ERR      = 3'd6
    } du_state_t;

    // Number of bytes needed to carry a latch dump of nb_bits bits.
    function automatic int unsigned latch_bytes(input int unsigned nb_bits);
        return (nb_bits + 32'd7) / 32'd8;
    endfunction

    // Op codes 0 and 7 are reserved and never sent to the target.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    // Commands whose whole response is a single acknowledge byte.
    function automatic logic op_is_ack(input logic [2:0] op);
        return (op == OP_LOAD_INST) || (op == OP_RUN) || (op == OP_STEP);
    endfunction

endpackage

// File: rtl/du_rsp_packer.sv
// Packs received response bytes (MSB first) into words. A full group or
// the final byte of a response emits one word; a short final group is
// left-aligned and zero-padded, except single-byte acks which stay
// right-aligned so the ack reads back as 0x000000AA.
module du_rsp_packer #(
    parameter int NB_REG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    input  logic              align_left,
    output logic [NB_REG-1:0] rsp_word,
    output logic              rsp_valid,
    output logic              rsp_last
);

    localparam int NB_BYTES = NB_REG / 8;
    localparam int CW       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [NB_REG-1:0] shift_r;
    logic [CW-1:0]     cnt_r;
    logic [NB_REG-1:0] word_r;
    logic              valid_r;
    logic              last_r;
    logic [NB_REG-1:0] merged_s;
    logic [NB_REG-1:0] aligned_s;
    logic              group_full_s;

    // Merge the incoming byte and left-align a short final group
    always_comb begin
        merged_s     = {shift_r[NB_REG-9:0], byte_data};
        group_full_s = (cnt_r == CW'(NB_BYTES - 1));
        if (align_left) begin
            aligned_s = merged_s << (8 * (NB_BYTES - 1 - int'(cnt_r)));
        end else begin
            aligned_s = merged_s;
        end
    end

    // Shift register, byte counter and one-cycle word strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= '0;
            cnt_r   <= '0;
            word_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            if (flush) begin
                shift_r <= '0;
                cnt_r   <= '0;
            end else if (byte_valid) begin
                if (group_full_s || byte_last) begin
                    word_r  <= aligned_s;
                    valid_r <= 1'b1;
                    last_r  <= byte_last;
                    shift_r <= '0;
                    cnt_r   <= '0;
                end else begin
                    shift_r <= merged_s;
                    cnt_r   <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign rsp_word  = word_r;
    assign rsp_valid = valid_r;
    assign rsp_last  = last_r;

endmodule

// File: rtl/du_host_link.sv
// Host-side command controller for the debug unit: accepts a command,
// sends its op byte and argument bytes over the UART byte link one at a
// time, then collects the target's response and hands it out as words.
// Optional build macro DU_HOST_TIMEOUT_EN adds a receive/transmit idle
// watchdog of TIMEOUT_CYC cycles (RUN is exempt while awaiting its ack).
module du_host_link
    import du_proto_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_R_INT    = 341,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [NB_REG-1:0] i_cmd_arg,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    output logic [NB_REG-1:0] o_rsp_word,
    output logic              o_rsp_valid,
    output logic              o_rsp_last,
    output logic              o_busy,
    output logic              o_err
);

    localparam int LATCH_BYTES = int'(latch_bytes(NB_R_INT));
    localparam int RX_MAX      = (LATCH_BYTES > 4) ? LATCH_BYTES : 4;
    localparam int RXW         = $clog2(RX_MAX + 1);

    du_state_t         state_r;
    logic [2:0]        op_r;
    logic [NB_REG-1:0] arg_sh_r;
    logic [2:0]        arg_left_r;
    logic [RXW-1:0]    rx_left_r;
    logic [7:0]        tx_data_r;
    logic              tx_start_r;
    logic              err_r;
    logic              busy_r;
    logic              cmd_ready_r;

    logic              enter_recv_s;
    logic              rx_take_s;
    logic              ack_cmd_s;
    logic              rx_bad_s;
    logic              rx_last_s;
    logic              pack_valid_s;
    logic              to_hit_s;

    // Argument bytes that follow the op byte.
    function automatic logic [2:0] arg_len(input logic [2:0] op);
        case (op)
            OP_LOAD_INST, OP_READ_MEM: return 3'd4;
            OP_READ_REG:               return 3'd1;
            default:                   return 3'd0;
        endcase
    endfunction

    // Response bytes the target returns for each command.
    function automatic logic [RXW-1:0] rsp_len(input logic [2:0] op);
        case (op)
            OP_LOAD_INST, OP_RUN, OP_STEP: return RXW'(1);
            OP_READ_REG, OP_READ_MEM:      return RXW'(4);
            OP_READ_LATCH:                 return RXW'(LATCH_BYTES);
            default:                       return RXW'(0);
        endcase
    endfunction

    // Decide whether a received byte is taken this cycle and whether it is a bad ack
    always_comb begin
        enter_recv_s = (state_r == ST_WAIT_TX) && i_tx_done && (arg_left_r == 3'd0);
        rx_take_s    = i_rx_done && ((state_r == ST_RECV) || enter_recv_s);
        ack_cmd_s    = op_is_ack(op_r);
        rx_bad_s     = rx_take_s && ack_cmd_s && (i_rx_data != ACK_BYTE);
        rx_last_s    = (rx_left_r == RXW'(1));
        pack_valid_s = rx_take_s && !rx_bad_s;
    end

`ifdef DU_HOST_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    logic [TOW-1:0] to_cnt_r;
    logic           to_active_s;
    logic           to_kick_s;

    // Watchdog runs while waiting on the link; RUN may wait forever for its ack
    always_comb begin
        to_active_s = (state_r == ST_WAIT_TX) ||
                      ((state_r == ST_RECV) && (op_r != OP_RUN));
        to_kick_s   = i_tx_done || i_rx_done;
        to_hit_s    = to_active_s && !to_kick_s &&
                      (to_cnt_r == TOW'(TIMEOUT_CYC - 1));
    end

    // Idle-cycle counter, restarted by any link activity
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            to_cnt_r <= '0;
        end else if (!to_active_s || to_kick_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TOW'(1);
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Command sequencing FSM with registered link and status outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 3'd0;
            arg_sh_r    <= '0;
            arg_left_r  <= 3'd0;
            rx_left_r   <= '0;
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_cmd_valid && cmd_ready_r) begin
                        op_r        <= i_cmd_op;
                        arg_left_r  <= arg_len(i_cmd_op);
                        rx_left_r   <= rsp_len(i_cmd_op);
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        if (i_cmd_op == OP_READ_REG) begin
                            arg_sh_r <= {3'b000, i_cmd_arg[4:0], {(NB_REG-8){1'b0}}};
                        end else begin
                            arg_sh_r <= i_cmd_arg;
                        end
                        if (op_is_legal(i_cmd_op)) begin
                            err_r   <= 1'b0;
                            state_r <= ST_SEND_OP;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= ST_ERR;
                        end
                    end
                end
                ST_SEND_OP: begin
                    tx_data_r  <= {5'b00000, op_r};
                    tx_start_r <= 1'b1;
                    state_r    <= ST_WAIT_TX;
                end
                ST_SEND_ARG: begin
                    tx_data_r  <= arg_sh_r[NB_REG-1 -: 8];
                    arg_sh_r   <= arg_sh_r << 4'd8;
                    arg_left_r <= arg_left_r - 3'd1;
                    tx_start_r <= 1'b1;
                    state_r    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (arg_left_r != 3'd0) begin
                            state_r <= ST_SEND_ARG;
                        end else begin
                            state_r <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    state_r <= ST_RECV;
                end
                ST_DELIVER, ST_ERR: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase

            // A byte may land in the same cycle the FSM moves into RECV.
            if (rx_take_s) begin
                if (rx_bad_s) begin
                    state_r <= ST_ERR;
                    err_r   <= 1'b1;
                end else begin
                    rx_left_r <= rx_left_r - RXW'(1);
                    if (rx_last_s) begin
                        state_r <= ST_DELIVER;
                    end
                end
            end

            if (to_hit_s) begin
                state_r <= ST_ERR;
                err_r   <= 1'b1;
            end
        end
    end

    du_rsp_packer #(
        .NB_REG (NB_REG)
    ) u_packer (
        .clk        (i_clk),
        .rst        (i_reset),
        .flush      (state_r == ST_IDLE),
        .byte_valid (pack_valid_s),
        .byte_data  (i_rx_data),
        .byte_last  (rx_last_s),
        .align_left (!ack_cmd_s),
        .rsp_word   (o_rsp_word),
        .rsp_valid  (o_rsp_valid),
        .rsp_last   (o_rsp_last)
    );

    assign o_tx_data   = tx_data_r;
    assign o_tx_start  = tx_start_r;
    assign o_err       = err_r;
    assign o_busy      = busy_r;
    assign o_cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_du_host_link.sv
// Scoreboard bench for du_host_link: a reference model predicts tx bytes
// and response words per command; a UART-side responder checks each
// transmitted byte and a monitor checks each response word.
module tb_du_host_link;

    localparam int NB_REG      = 32;
    localparam int NB_R_INT    = 341;
    localparam int TIMEOUT_CYC = 100;
    localparam int LATCH_BYTES = (NB_R_INT + 7) / 8;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } rsp_t;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [2:0]        i_cmd_op;
    logic [NB_REG-1:0] i_cmd_arg;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              i_tx_done;
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic [NB_REG-1:0] o_rsp_word;
    logic              o_rsp_valid;
    logic              o_rsp_last;
    logic              o_busy;
    logic              o_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  tx_q[$];
    rsp_t        rsp_q[$];
    bit          tx_busy  = 1'b0;
    int unsigned cyc        = 0;
    int unsigned rxdone_cyc = 0;
    int unsigned txdone_cyc = 0;

    always #5 i_clk = ~i_clk;

    du_host_link #(
        .NB_REG      (NB_REG),
        .NB_R_INT    (NB_R_INT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_arg   (i_cmd_arg),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .i_tx_done   (i_tx_done),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .o_rsp_word  (o_rsp_word),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_last  (o_rsp_last),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cycle bookkeeping used for latency checks.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_rx_done) rxdone_cyc <= cyc;
        if (i_tx_done) txdone_cyc <= cyc;
    end

    // UART transmitter model: checks each started byte, answers with tx_done.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start === 1'b1) begin
                tx_busy = 1'b1;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %02h, expected no byte", o_tx_data);
                end else begin
                    check("tx_byte", o_tx_data, tx_q.pop_front());
                end
                repeat ($urandom_range(0, 3)) @(negedge i_clk);
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_rsp_valid === 1'b1) begin
                check("rsp_latency", cyc, rxdone_cyc + 1);
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got word %08h, expected no word", o_rsp_word);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_word", o_rsp_word, e.word);
                    check("rsp_last", o_rsp_last, e.last);
                end
            end
        end
    end

    function automatic int rsp_bytes(input logic [2:0] op);
        if (op >= 3'd1 && op <= 3'd3) return 1;
        if (op == 3'd4 || op == 3'd5) return 4;
        if (op == 3'd6) return LATCH_BYTES;
        return 0;
    endfunction

    // Predicted transmit bytes: op code, then argument MSB first.
    task automatic push_tx(input logic [2:0] op, input logic [31:0] arg);
        tx_q.push_back({5'd0, op});
        if (op == 3'd1 || op == 3'd5) begin
            for (int k = 3; k >= 0; k--) tx_q.push_back(8'((arg >> (8 * k)) & 32'hFF));
        end else if (op == 3'd4) begin
            tx_q.push_back(8'(arg % 32));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"},  o_tx_start,  1'b0);
        check({tag, "_tx_data"},   o_tx_data,   8'h00);
        check({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
        check({tag, "_rsp_last"},  o_rsp_last,  1'b0);
        check({tag, "_rsp_word"},  o_rsp_word,  32'h0);
        check({tag, "_err"},       o_err,       1'b0);
        check({tag, "_busy"},      o_busy,      1'b0);
        check({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] arg);
        check("cmd_ready", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_arg   = arg;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'($urandom);
        i_cmd_arg   = $urandom;
    endtask

    task automatic wait_tx_drain();
        int guard = 0;
        while ((tx_q.size() != 0 || tx_busy) && guard < 500) begin
            @(negedge i_clk);
            guard++;
        end
        check("tx_drain_in_time", guard < 500, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    // One full command: model prediction, drive, answer, final status checks.
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] arg, input byte_q_t rx);
        bit          legal;
        bit          exp_err;
        int          n;
        int          guard;
        logic [31:0] w;
        rsp_t        r;
        legal   = (op >= 3'd1) && (op <= 3'd6);
        exp_err = !legal;
        if (legal) begin
            push_tx(op, arg);
            if (op <= 3'd3) begin
                if (rx[0] == 8'hAA) begin
                    r.word = 32'h0000_00AA;
                    r.last = 1'b1;
                    rsp_q.push_back(r);
                end else begin
                    exp_err = 1'b1;
                end
            end else begin
                n = rx.size();
                for (int i = 0; i < n; i += 4) begin
                    w = 32'h0;
                    for (int j = 0; j < 4; j++)
                        w = (w << 8) | ((i + j < n) ? 32'(rx[i + j]) : 32'h0);
                    r.word = w;
                    r.last = (i + 4 >= n);
                    rsp_q.push_back(r);
                end
            end
        end
        issue(op, arg);
        if (legal) begin
            wait_tx_drain();
            foreach (rx[i]) send_rx(rx[i]);
        end
        guard = 0;
        while (o_busy !== 1'b0 && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        check("cmd_complete", o_busy, 1'b0);
        check("err_flag", o_err, exp_err);
        check("rsp_all_seen", rsp_q.size(), 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        check_reset_outputs("in_reset");
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t rx;
        logic [2:0]  op;
        logic [7:0]  b;
        int          guard;

        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 3'd0;
        i_cmd_arg   = '0;
        i_rx_data   = 8'h00;
        i_rx_done   = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("post_reset");

        rx = '{8'hAA};
        run_cmd(3'd1, 32'h8C22_0004, rx);
        rx = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_cmd(3'd4, 32'd5, rx);
        rx = {};
        for (int i = 0; i < LATCH_BYTES; i++) rx.push_back(8'(i));
        run_cmd(3'd6, 32'h0, rx);
        rx = '{8'h55};
        run_cmd(3'd3, 32'h0, rx);
        rx = '{8'hAA};
        run_cmd(3'd2, 32'h0, rx);
        rx = {};
        run_cmd(3'd0, 32'h1234, rx);
        run_cmd(3'd7, 32'h5678, rx);

        // Reset in the middle of a READ_MEM response.
        push_tx(3'd5, 32'hDEAD_BEEF);
        issue(3'd5, 32'hDEAD_BEEF);
        wait_tx_drain();
        send_rx(8'h11);
        send_rx(8'h22);
        do_reset();
        check("reset_no_rsp_pending", rsp_q.size(), 0);
        rx = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_cmd(3'd5, 32'h0000_0100, rx);

`ifdef DU_HOST_TIMEOUT_EN
        push_tx(3'd4, 32'd7);
        issue(3'd4, 32'd7);
        wait_tx_drain();
        guard = 0;
        while (o_err !== 1'b1 && guard < 400) begin
            @(negedge i_clk);
            guard++;
        end
        check("timeout_raised", o_err, 1'b1);
        check("timeout_latency", cyc - txdone_cyc - 1, 100);
        @(negedge i_clk);
        check("timeout_idle", o_busy, 1'b0);
`else
        push_tx(3'd4, 32'd7);
        issue(3'd4, 32'd7);
        wait_tx_drain();
        repeat (300) @(negedge i_clk);
        check("no_timeout_busy", o_busy, 1'b1);
        check("no_timeout_err", o_err, 1'b0);
        do_reset();
`endif

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) send_rx(8'($urandom));
            op = 3'($urandom_range(0, 7));
            rx = {};
            for (int i = 0; i < rsp_bytes(op); i++) begin
                if (op >= 3'd1 && op <= 3'd3) begin
                    if ($urandom_range(0, 3) == 0) begin
                        do b = 8'($urandom); while (b == 8'hAA);
                    end else begin
                        b = 8'hAA;
                    end
                end else begin
                    b = 8'($urandom);
                end
                rx.push_back(b);
            end
            run_cmd(op, $urandom, rx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
